// File: rtl/hazard_tracker.sv
// hazard_tracker: pipeline hazard unit for a 5-stage in-order core.
// Tracks the destination of the instructions in EX, MEM and WB. It
// generates a load-use stall and forwarding mux selects for the decode
// instruction, and it produces the registered register-file write port.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   id_valid          - decode stage holds a valid instruction
//   id_rs, id_rt      - decode source registers
//   id_use_rs/_rt     - decode instruction reads rs / rt
//   id_dst, id_we     - decode destination register and write enable
//   id_is_load        - decode instruction is a load
//   flush             - squash the decode instruction
//   stall             - hold PC and IF/ID (combinational)
//   fwd_a_sel/_b_sel  - forwarding selects: 00 regfile, 01 EX, 10 MEM, 11 WB
//   wb_we, wb_dst     - register-file write enable / address (from WB entry)
//   stall_cnt         - saturating count of stall cycles
module hazard_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             wb_we,
  output logic [4:0]       wb_dst,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       we;
    logic       ld;
  } entry_t;

  entry_t ex_q, mem_q, wb_q, ex_d;

  // Register 0 is hardwired, so an entry targeting it never produces a value.
  function automatic logic is_writer(input entry_t e);
    return e.v & e.we & (e.dst != 5'd0);
  endfunction

  // Nearest producer wins. A load still in EX has no value yet; that case
  // is covered by the stall, so it is not a forwarding source here.
  function automatic logic [1:0] fwd_pick(input logic [4:0] src,
                                          input entry_t ex,
                                          input entry_t mem,
                                          input entry_t wb);
    if (is_writer(ex) && !ex.ld && ex.dst == src)
      return 2'b01;
    else if (is_writer(mem) && mem.dst == src)
      return 2'b10;
    else if (is_writer(wb) && wb.dst == src)
      return 2'b11;
    else
      return 2'b00;
  endfunction

  always_comb begin
    stall = id_valid && is_writer(ex_q) && ex_q.ld &&
            ((id_use_rs && id_rs == ex_q.dst) || (id_use_rt && id_rt == ex_q.dst));

    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (id_valid && !stall) begin
      if (id_use_rs) fwd_a_sel = fwd_pick(id_rs, ex_q, mem_q, wb_q);
      if (id_use_rt) fwd_b_sel = fwd_pick(id_rt, ex_q, mem_q, wb_q);
    end

    // Bubbles carry all-zero fields so wb_dst reads 0 when nothing retires.
    ex_d = '0;
    if (id_valid && !stall && !flush) begin
      ex_d.v   = 1'b1;
      ex_d.dst = id_dst;
      ex_d.we  = id_we;
      ex_d.ld  = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      // A flushed decode instruction is not really stalled; do not count it.
      if (stall && !flush && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign wb_we  = is_writer(wb_q);
  assign wb_dst = wb_q.dst;

endmodule
